// File: rtl/pipe_chain.sv
// In-order pipeline register chain with stall, bubble and flush control, a retire counter and a forwarding lookup.
// Define PIPE_CHAIN_FWD_EN to build the forwarding comparators; without it, fwd_* outputs are tied to zero.
module pipe_chain #(
    parameter int WORD_SIZE    = 16,
    parameter int STAGES       = 3,
    parameter int CTRL_W       = 12,
    parameter int DEST_W       = 2,
    parameter int FLUSH_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic [DEST_W-1:0]    in_dest,
    input  logic                 in_wen,
    output logic                 in_ready,
    input  logic                 stall,
    input  logic                 bubble,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [WORD_SIZE-1:0] out_data,
    output logic [DEST_W-1:0]    out_dest,
    output logic                 out_wen,
    input  logic [DEST_W-1:0]    src_addr1,
    input  logic [DEST_W-1:0]    src_addr2,
    output logic                 fwd_hit1,
    output logic                 fwd_hit2,
    output logic [WORD_SIZE-1:0] fwd_data1,
    output logic [WORD_SIZE-1:0] fwd_data2,
    output logic [WORD_SIZE-1:0] num_inst
);

    typedef struct packed {
        logic                 valid;
        logic                 wen;
        logic [DEST_W-1:0]    dest;
        logic [WORD_SIZE-1:0] data;
        logic [CTRL_W-1:0]    ctrl;
    } stage_t;

    stage_t st [STAGES];
    logic   advance;
    logic   retire;

    assign advance  = !stall;
    assign retire   = advance && st[STAGES-1].valid;
    assign in_ready = !stall && !bubble && !flush;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        // A flush kills the young stages; the first surviving stage inherits a killed entry when moving.
        localparam bit KILL  = (i < FLUSH_STAGES);
        localparam bit ENTRY = (i == FLUSH_STAGES);
        stage_t nxt;

        if (i == 0) begin : g_head
            assign nxt = '{valid: in_valid && !bubble,
                           wen:   in_wen && in_valid && !bubble,
                           dest:  in_dest,
                           data:  in_data,
                           ctrl:  in_ctrl};
        end else begin : g_body
            assign nxt = st[i-1];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                st[i] <= '0;
            end else begin
                if (advance) begin
                    st[i] <= nxt;
                end
                if (flush && (KILL || (ENTRY && advance))) begin
                    st[i].valid <= 1'b0;
                    st[i].wen   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_inst <= '0;
        end else if (retire) begin
            num_inst <= num_inst + WORD_SIZE'(1);
        end
    end

    assign out_valid = st[STAGES-1].valid;
    assign out_ctrl  = st[STAGES-1].ctrl;
    assign out_data  = st[STAGES-1].data;
    assign out_dest  = st[STAGES-1].dest;
    assign out_wen   = st[STAGES-1].wen;

`ifdef PIPE_CHAIN_FWD_EN
    // Priority chain built from the oldest stage down, so the youngest match wins.
    logic [STAGES:0]      hit1_c;
    logic [STAGES:0]      hit2_c;
    logic [WORD_SIZE-1:0] data1_c [STAGES+1];
    logic [WORD_SIZE-1:0] data2_c [STAGES+1];

    assign hit1_c[STAGES]  = 1'b0;
    assign hit2_c[STAGES]  = 1'b0;
    assign data1_c[STAGES] = '0;
    assign data2_c[STAGES] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_fwd
        logic match1;
        logic match2;
        assign match1     = st[k].valid && st[k].wen && (st[k].dest == src_addr1);
        assign match2     = st[k].valid && st[k].wen && (st[k].dest == src_addr2);
        assign hit1_c[k]  = match1 || hit1_c[k+1];
        assign hit2_c[k]  = match2 || hit2_c[k+1];
        assign data1_c[k] = match1 ? st[k].data : data1_c[k+1];
        assign data2_c[k] = match2 ? st[k].data : data2_c[k+1];
    end

    assign fwd_hit1  = hit1_c[0];
    assign fwd_hit2  = hit2_c[0];
    assign fwd_data1 = data1_c[0];
    assign fwd_data2 = data2_c[0];
`else
    logic unused_src;
    assign unused_src = ^{src_addr1, src_addr2};
    assign fwd_hit1   = 1'b0;
    assign fwd_hit2   = 1'b0;
    assign fwd_data1  = '0;
    assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Directed self-checking bench for pipe_chain at default parameters.
module tb_pipe_chain;

`ifdef PIPE_CHAIN_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [11:0] in_ctrl = '0;
    logic [15:0] in_data = '0;
    logic [1:0]  in_dest = '0;
    logic        in_wen = 1'b0;
    logic        in_ready;
    logic        stall = 1'b0;
    logic        bubble = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [11:0] out_ctrl;
    logic [15:0] out_data;
    logic [1:0]  out_dest;
    logic        out_wen;
    logic [1:0]  src_addr1 = '0;
    logic [1:0]  src_addr2 = '0;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [15:0] fwd_data1;
    logic [15:0] fwd_data2;
    logic [15:0] num_inst;

    int errors = 0;
    int checks = 0;

    pipe_chain dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .in_dest(in_dest), .in_wen(in_wen), .in_ready(in_ready),
        .stall(stall), .bubble(bubble), .flush(flush),
        .out_valid(out_valid), .out_ctrl(out_ctrl), .out_data(out_data),
        .out_dest(out_dest), .out_wen(out_wen),
        .src_addr1(src_addr1), .src_addr2(src_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .num_inst(num_inst)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic v, input logic [15:0] d, input logic [1:0] dst, input logic w);
        in_valid = v;
        in_data  = d;
        in_ctrl  = d[11:0] ^ 12'h5A5;
        in_dest  = dst;
        in_wen   = w;
    endtask

    initial begin
        // reset with competing controls asserted
        stall = 1'b1; flush = 1'b1; bubble = 1'b1; in_valid = 1'b1; in_wen = 1'b1;
        step(); step();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; bubble = 1'b0; in_valid = 1'b0; in_wen = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data",  32'(out_data), 0);
        check("rst_out_ctrl",  32'(out_ctrl), 0);
        check("rst_num_inst",  32'(num_inst), 0);
        check("rst_fwd_hit1",  32'(fwd_hit1), 0);
        check("rst_in_ready",  32'(in_ready), 1);
        stall = 1'b1;  #1 check("ready_stall",  32'(in_ready), 0);
        stall = 1'b0; bubble = 1'b1; #1 check("ready_bubble", 32'(in_ready), 0);
        bubble = 1'b0; flush = 1'b1; #1 check("ready_flush",  32'(in_ready), 0);
        flush = 1'b0;

        // streaming: data 1..5, outputs on edges 3..7, retires on edges 4..8
        for (int c = 1; c <= 8; c++) begin
            push(c <= 5, 16'(c), 2'(c), 1'b1);
            step();
            check("stream_valid", 32'(out_valid), (c >= 3 && c <= 7) ? 1 : 0);
            if (c >= 3 && c <= 7) begin
                check("stream_data", 32'(out_data), 32'(c - 2));
                check("stream_ctrl", 32'(out_ctrl), 32'(12'(c - 2) ^ 12'h5A5));
            end
            check("stream_num", 32'(num_inst), (c >= 4) ? 32'(c - 3) : 0);
        end

        // stall hold with three entries in flight
        push(1, 16'd10, 2'd0, 1'b1); step();
        push(1, 16'd11, 2'd0, 1'b1); step();
        push(1, 16'd12, 2'd0, 1'b1); step();
        check("stall_pre_data", 32'(out_data), 10);
        check("stall_pre_num",  32'(num_inst), 5);
        stall = 1'b1; push(1, 16'd99, 2'd0, 1'b1);
        #1 check("stall_ready", 32'(in_ready), 0);
        for (int c = 0; c < 4; c++) begin
            step();
            check("stall_valid", 32'(out_valid), 1);
            check("stall_data",  32'(out_data), 10);
            check("stall_num",   32'(num_inst), 5);
        end
        stall = 1'b0; push(0, 16'd0, 2'd0, 1'b0);
        step(); check("resume_data1", 32'(out_data), 11); check("resume_num1", 32'(num_inst), 6);
        step(); check("resume_data2", 32'(out_data), 12); check("resume_num2", 32'(num_inst), 7);
        step(); check("resume_empty", 32'(out_valid), 0); check("resume_num3", 32'(num_inst), 8);

        // flush together with stall: stages hold A(0), B(1), C(2)
        push(1, 16'h000C, 2'd1, 1'b1); step();
        push(1, 16'h000B, 2'd1, 1'b1); step();
        push(1, 16'h000A, 2'd1, 1'b1); step();
        check("flush_pre_data", 32'(out_data), 32'h000C);
        flush = 1'b1; stall = 1'b1; push(1, 16'h00EE, 2'd1, 1'b1);
        #1 check("flush_ready", 32'(in_ready), 0);
        step();
        check("flush_out_valid", 32'(out_valid), 1);
        check("flush_out_data",  32'(out_data), 32'h000C);
        check("flush_num",       32'(num_inst), 8);
        src_addr1 = 2'd1;
        #1;
        check("flush_fwd_hit",  32'(fwd_hit1), FWD ? 1 : 0);
        check("flush_fwd_data", 32'(fwd_data1), FWD ? 32'h000C : 0);
        flush = 1'b0; stall = 1'b0; push(0, 16'd0, 2'd0, 1'b0);
        step(); check("flush_s1_dead", 32'(out_valid), 0); check("flush_retire_c", 32'(num_inst), 9);
        step(); check("flush_s0_dead", 32'(out_valid), 0); check("flush_num_hold", 32'(num_inst), 9);

        // forwarding: stage0 {1,AA}, stage1 {2,33}, stage2 {1,55}
        push(1, 16'h0055, 2'd1, 1'b1); step();
        push(1, 16'h0033, 2'd2, 1'b1); step();
        push(1, 16'h00AA, 2'd1, 1'b1); step();
        stall = 1'b1; push(0, 16'd0, 2'd0, 1'b0);
        src_addr1 = 2'd1; src_addr2 = 2'd2;
        #1;
        check("fwd_hit1",  32'(fwd_hit1), FWD ? 1 : 0);
        check("fwd_data1", 32'(fwd_data1), FWD ? 32'h00AA : 0);
        check("fwd_hit2",  32'(fwd_hit2), FWD ? 1 : 0);
        check("fwd_data2", 32'(fwd_data2), FWD ? 32'h0033 : 0);
        src_addr2 = 2'd3;
        #1;
        check("fwd_miss_hit",  32'(fwd_hit2), 0);
        check("fwd_miss_data", 32'(fwd_data2), 0);
        stall = 1'b0;
        step(); check("fwd_drain1", 32'(out_data), 32'h0033); check("fwd_num1", 32'(num_inst), 10);
        step(); check("fwd_drain2", 32'(out_data), 32'h00AA); check("fwd_num2", 32'(num_inst), 11);
        step(); check("fwd_drain3", 32'(out_valid), 0);       check("fwd_num3", 32'(num_inst), 12);

        // bubble inserts a hole without stalling
        push(1, 16'h0071, 2'd0, 1'b1); step();
        push(1, 16'h0072, 2'd0, 1'b1); bubble = 1'b1;
        #1 check("bubble_ready", 32'(in_ready), 0);
        step();
        bubble = 1'b0; push(1, 16'h0073, 2'd0, 1'b1); step();
        push(0, 16'd0, 2'd0, 1'b0);
        check("bubble_x_data", 32'(out_data), 32'h0071);
        step(); check("bubble_hole", 32'(out_valid), 0); check("bubble_num1", 32'(num_inst), 13);
        step(); check("bubble_y_data", 32'(out_data), 32'h0073); check("bubble_num2", 32'(num_inst), 13);
        step(); check("bubble_empty", 32'(out_valid), 0); check("bubble_num3", 32'(num_inst), 14);

        // counter wrap from a forced preload
        force dut.num_inst = 16'hFFFC;
        step();
        release dut.num_inst;
        #1 check("wrap_preload", 32'(num_inst), 32'hFFFC);
        for (int c = 1; c <= 8; c++) begin
            push(c <= 5, 16'(c + 32), 2'd3, 1'b1);
            step();
            check("wrap_num", 32'(num_inst), (c >= 4) ? 32'(16'(16'hFFFC + c - 3)) : 32'hFFFC);
        end
        check("wrap_final", 32'(num_inst), 1);

        // reset mid-stream discards in-flight entries
        push(1, 16'h0041, 2'd0, 1'b1); step();
        push(1, 16'h0042, 2'd0, 1'b1); step();
        push(1, 16'h0043, 2'd0, 1'b1); step();
        check("mid_pre_valid", 32'(out_valid), 1);
        reset = 1'b1; stall = 1'b1; flush = 1'b1;
        step();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; push(0, 16'd0, 2'd0, 1'b0);
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_data",  32'(out_data), 0);
        check("mid_rst_num",   32'(num_inst), 0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("mid_rst_drain_valid", 32'(out_valid), 0);
            check("mid_rst_drain_num",   32'(num_inst), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 Parameter WORD_SIZE, default 16, width of the payload data and the num_inst counter.
REQ-002 Parameter STAGES, default 3, number of pipeline stages (legal 2..8); stage 0 is youngest and stage STAGES-1 is oldest.
REQ-003 Parameter CTRL_W, default 12, width of the latched control bundle.
REQ-004 Parameter DEST_W, default 2, width of the register-file destination index.
REQ-005 Parameter FLUSH_STAGES, default 2, number of youngest stages killed by flush (legal 1..STAGES).
REQ-006 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-007 Port: reset  input  1  synchronous, active-high reset.
REQ-008 Ports, all inputs, presented at stage 0:
- in_valid (1): instruction present.
- in_ctrl (CTRL_W): control bundle.
- in_data (WORD_SIZE): payload word.
- in_dest (DEST_W): destination register.
- in_wen (1): instruction writes the register file.
REQ-009 Port: in_ready  output  1  the stage-0 input is accepted this cycle.
REQ-010 Port: stall  input  1  hold the entire chain.
REQ-011 Port: bubble  input  1  inject an invalid entry at stage 0 and refuse the input.
REQ-012 Port: flush  input  1  kill stages 0..FLUSH_STAGES-1.
REQ-013 Ports, all outputs, driven from stage STAGES-1: out_valid (1), out_ctrl (CTRL_W), out_data (WORD_SIZE), out_dest (DEST_W), out_wen (1).
REQ-014 Ports, forwarding lookup:
- src_addr1, src_addr2: inputs, DEST_W.
- fwd_hit1, fwd_hit2: outputs, 1.
- fwd_data1, fwd_data2: outputs, WORD_SIZE.
REQ-015 Port: num_inst  output  WORD_SIZE  count of retired valid instructions.

Function
REQ-016 Each stage SHALL hold a valid bit plus a registered copy of ctrl, data, dest and wen; out_* SHALL be the registered contents of stage STAGES-1, with no combinational path from in_*.
REQ-017 Advance = !stall; on an advance, stage[i] SHALL take stage[i-1] for i>=1.
REQ-018 On an advance, stage 0 SHALL take the in_* values with valid=in_valid when bubble=0, and SHALL take valid=0 when bubble=1.
REQ-019 in_ready SHALL equal !stall && !bubble && !flush, combinationally.
REQ-020 When stall=1 and flush=0, every stage SHALL hold its contents and num_inst SHALL hold.
REQ-021 Flush SHALL take priority over stall and bubble: on the flush edge, valid bits of stages 0..FLUSH_STAGES-1 SHALL be cleared.
REQ-022 On the flush edge, the older stages SHALL advance if stall=0 and SHALL hold if stall=1.
REQ-023 On a flush edge with stall=0, stage FLUSH_STAGES SHALL receive an invalid entry; the flushed input is not accepted.
REQ-024 Retire event = advance && out_valid; each retire SHALL increment num_inst by 1 on that edge.
REQ-025 num_inst SHALL wrap modulo 2^WORD_SIZE, so 16'hFFFF+1 = 0.
REQ-026 An invalid entry SHALL never retire, forward, or be counted.
REQ-027 The payload of an invalid stage is don't-care, but the stage's wen SHALL be forced to 0 when it is invalidated.
REQ-028 fwd_hitN SHALL be 1 when some stage k has valid=1, wen=1 and dest==src_addrN.
REQ-029 fwd_dataN SHALL be the data of the youngest (lowest k) such matching stage; when no stage matches, fwd_hitN=0 and fwd_dataN=0.
REQ-030 The lookup SHALL be purely combinational on current register state, so a hit is visible in the same cycle.

Reset
REQ-031 While reset=1 at a rising edge, all valid bits SHALL clear, all stage payloads SHALL be 0, and num_inst SHALL be 0.
REQ-032 Reset SHALL take priority over stall, flush and bubble.
REQ-033 In the first cycle after reset: out_valid=0, out_* payload=0, num_inst=0, fwd_hit*=0, and in_ready = !stall && !bubble && !flush.
REQ-034 A reset asserted mid-stream SHALL discard all in-flight entries without counting them.

Configuration
REQ-035 Macro PIPE_CHAIN_FWD_EN, when defined, SHALL compile in the forwarding comparators and mux of REQ-028..030.
REQ-036 When PIPE_CHAIN_FWD_EN is undefined, fwd_hit1/2 SHALL be constant 0 and fwd_data1/2 SHALL be constant 0; ports are unchanged and all other behaviour is identical.

Verification
REQ-037 Streaming (defaults): present 5 valid instrs, data 1..5, stall=bubble=flush=0 -> out_data 1..5 appears on cycles 3..7 after first accept, and num_inst=5.
REQ-038 Stall hold: stall=1 for 4 cycles with 3 valid entries in flight -> all out_* and num_inst are unchanged, in_ready=0, and streaming resumes with no loss or duplication.
REQ-039 Flush vs stall: with stages holding A,B,C (0..2), assert flush and stall together -> stages 0,1 become invalid, C stays at the output, and num_inst is unchanged.
REQ-040 Forwarding (PIPE_CHAIN_FWD_EN defined): stage0 {dest=1, data=0x00AA, wen=1}, stage2 {dest=1, data=0x0055, wen=1}, src_addr1=1 -> fwd_hit1=1 and fwd_data1=0x00AA.
REQ-041 Same stimulus as REQ-040 with the macro undefined -> fwd_hit1=0 and fwd_data1=0.
REQ-042 Wrap: preload num_inst to 16'hFFFE via 2 retires after forcing, retire 3 more -> num_inst=1; then assert reset mid-stream -> all valid=0 and num_inst=0 on the next cycle.
